seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_to_hex.sv | 34 +++
 rtl/seg_scan_decoder.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph definitions (bit6..bit0 = g..a, active-high).
// The scan decoder and the forward hex-to-segment mapper both use this table.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index n holds the segment pattern that displays hex digit n.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h58, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h27, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Forward mapping: hex value to the pattern that displays it.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return GLYPH_TABLE[hex];
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup: segment pattern to hex value, with flags
// for a recognised glyph and for the all-off (blank) pattern.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       legal,
    output logic       blank
);

    logic [15:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign match[gi] = (seg == GLYPH_TABLE[gi]);
        end
    endgenerate

    // Encode the matching table entry; table entries are distinct so at most one hits.
    always_comb begin
        hex   = 4'd0;
        legal = |match;
        for (int i = 0; i < 16; i++) begin
            if (match[i]) begin
                hex = 4'(i);
            end
        end
    end

    assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches a multiplexed seven-segment display (segment lines plus digit
// enables), waits for each scan step to settle, and keeps a per-position
// record of the decoded hex value with valid/error flags.
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     an,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     valid,
    output logic [NDIG-1:0]     err,
    output logic                upd,
    output logic [2:0]          upd_idx
);

    localparam int         W         = NDIG + 7;
    localparam logic [7:0] STABLE_C  = 8'(STABLE);
    localparam logic [7:0] STABLE_M1 = 8'(STABLE - 1);

    logic [1:0]      rst_sync_reg;
    logic            rst_hold;
    logic [W-1:0]    sync1_reg;
    logic [W-1:0]    s_reg;
    logic [W-1:0]    prev_reg;
    logic [7:0]      cnt_reg;
    logic [7:0]      cnt_next;
    logic [NDIG-1:0] s_an;
    logic [6:0]      s_seg;
    logic            run_done;
    logic            an_onehot;
    logic            cap_fire;
    logic [2:0]      cap_idx;
    logic [3:0]      dec_hex;
    logic            dec_legal;
    logic            dec_blank;
    logic            upd_reg;
    logic [2:0]      upd_idx_reg;

    // Reset asserts immediately but is held for two clock edges after rst falls,
    // so the counter and register file leave reset cleanly on a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_reg <= 2'b11;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b0};
        end
    end

    assign rst_hold = rst_sync_reg[1];

    // Two-flop synchronizer on the raw pins; it may start sampling during the
    // reset hold so the first post-reset sample is ready when state releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            s_reg     <= '0;
        end else begin
            sync1_reg <= {an, seg};
            s_reg     <= sync1_reg;
        end
    end

    assign s_an  = s_reg[W-1:7];
    assign s_seg = s_reg[6:0];

    // Stability counter: restarts at 1 on any sample change, saturates at STABLE.
    always_comb begin
        cnt_next = cnt_reg;
        if (s_reg != prev_reg) begin
            cnt_next = 8'd1;
        end else if (cnt_reg != STABLE_C) begin
            cnt_next = cnt_reg + 8'd1;
        end
    end

    // Previous-sample register and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg <= '0;
            cnt_reg  <= 8'd0;
        end else if (rst_hold) begin
            prev_reg <= '0;
            cnt_reg  <= 8'd0;
        end else begin
            prev_reg <= s_reg;
            cnt_reg  <= cnt_next;
        end
    end

    // A run completes only on the step into STABLE, so a saturated run never refires.
    assign run_done  = (s_reg == prev_reg) && (cnt_reg == STABLE_M1);
    assign an_onehot = (s_an != '0) && ((s_an & (s_an - NDIG'(1))) == '0);
    assign cap_fire  = run_done && an_onehot;

    // Position index of the single active digit enable.
    always_comb begin
        cap_idx = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (s_an[i]) begin
                cap_idx = 3'(i);
            end
        end
    end

    seg7_to_hex u_dec (
        .seg   (s_seg),
        .hex   (dec_hex),
        .legal (dec_legal),
        .blank (dec_blank)
    );

    // Capture strobe and index, registered alongside the register file update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_reg     <= 1'b0;
            upd_idx_reg <= 3'd0;
        end else if (rst_hold) begin
            upd_reg     <= 1'b0;
            upd_idx_reg <= 3'd0;
        end else begin
            upd_reg     <= cap_fire;
            upd_idx_reg <= cap_fire ? cap_idx : 3'd0;
        end
    end

    assign upd     = upd_reg;
    assign upd_idx = upd_idx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_pos
            logic [3:0] dig_reg;
            logic       valid_reg;
            logic       err_reg;

            // Per-position record; only the enabled position changes on a capture.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dig_reg   <= 4'd0;
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                end else if (rst_hold) begin
                    dig_reg   <= 4'd0;
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                end else if (cap_fire && s_an[gi]) begin
                    if (dec_legal) begin
                        dig_reg   <= dec_hex;
                        valid_reg <= 1'b1;
                        err_reg   <= 1'b0;
                    end else if (dec_blank) begin
                        dig_reg   <= 4'd0;
                        valid_reg <= 1'b0;
                        err_reg   <= 1'b0;
                    end else begin
                        valid_reg <= 1'b0;
                        err_reg   <= 1'b1;
                    end
                end
            end

            assign digits[4*gi +: 4] = dig_reg;
            assign valid[gi]         = valid_reg;
            assign err[gi]           = err_reg;
        end
    endgenerate

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (NDIG=4, STABLE=4).
module tb_seg_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;
    localparam int NVEC   = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [6:0]        seg = 7'h00;
    logic [NDIG-1:0]   an  = '0;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   valid;
    logic [NDIG-1:0]   err;
    logic              upd;
    logic [2:0]        upd_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int upd_n;
    int last_idx;
    int last_cyc;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          cyc;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  err;
        int          nupd;
        int          idx;
    } vec_t;

    vec_t vecs [NVEC];

    seg_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg     (seg),
        .an      (an),
        .digits  (digits),
        .valid   (valid),
        .err     (err),
        .upd     (upd),
        .upd_idx (upd_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each edge; records upd pulses.
    task automatic run(input int n);
        upd_n    = 0;
        last_idx = 0;
        last_cyc = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (upd === 1'b1) begin
                upd_n++;
                last_idx = int'(upd_idx);
                last_cyc = k;
            end else begin
                check("upd_idx_idle", {29'd0, upd_idx}, 32'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{4'b0001, 7'h5B, 10, 16'h0002, 4'h1, 4'h0, 1, 0};
        vecs[1]  = '{4'b0001, 7'h4F,  8, 16'h0003, 4'h1, 4'h0, 1, 0};
        vecs[2]  = '{4'b0010, 7'h66,  8, 16'h0043, 4'h3, 4'h0, 1, 1};
        vecs[3]  = '{4'b0100, 7'h27,  8, 16'h0743, 4'h7, 4'h0, 1, 2};
        vecs[4]  = '{4'b1000, 7'h71,  8, 16'hF743, 4'hF, 4'h0, 1, 3};
        vecs[5]  = '{4'b0010, 7'h06,  3, 16'hF743, 4'hF, 4'h0, 0, 0};
        vecs[6]  = '{4'b0010, 7'h5B,  3, 16'hF743, 4'hF, 4'h0, 0, 0};
        vecs[7]  = '{4'b0010, 7'h06,  3, 16'hF743, 4'hF, 4'h0, 0, 0};
        vecs[8]  = '{4'b0010, 7'h5B,  3, 16'hF743, 4'hF, 4'h0, 0, 0};
        vecs[9]  = '{4'b0100, 7'h12,  8, 16'hF743, 4'hB, 4'h4, 1, 2};
        vecs[10] = '{4'b0100, 7'h00,  8, 16'hF043, 4'hB, 4'h0, 1, 2};
        vecs[11] = '{4'b0110, 7'h7F, 20, 16'hF043, 4'hB, 4'h0, 0, 0};
        vecs[12] = '{4'b0000, 7'h7F, 20, 16'hF043, 4'hB, 4'h0, 0, 0};
        vecs[13] = '{4'b1000, 7'h79,  8, 16'hE043, 4'hB, 4'h0, 1, 3};
        vecs[14] = '{4'b0010, 7'h7C,  8, 16'hE0B3, 4'hB, 4'h0, 1, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", {16'd0, digits}, 32'd0);
        check("rst_valid", {28'd0, valid}, 32'd0);
        check("rst_err", {28'd0, err}, 32'd0);
        check("rst_upd", {31'd0, upd}, 32'd0);
        check("rst_upd_idx", {29'd0, upd_idx}, 32'd0);
        rst = 1'b0;
        run(4);
        check("idle_upd_count", upd_n, 0);

        // Table-driven scan sequence
        for (int i = 0; i < NVEC; i++) begin
            an  = vecs[i].an;
            seg = vecs[i].seg;
            run(vecs[i].cyc);
            check($sformatf("v%0d_upd_count", i), upd_n, vecs[i].nupd);
            check($sformatf("v%0d_digits", i), {16'd0, digits}, {16'd0, vecs[i].digits});
            check($sformatf("v%0d_valid", i), {28'd0, valid}, {28'd0, vecs[i].valid});
            check($sformatf("v%0d_err", i), {28'd0, err}, {28'd0, vecs[i].err});
            if (upd_n > 0) begin
                check($sformatf("v%0d_upd_idx", i), last_idx, vecs[i].idx);
                check($sformatf("v%0d_upd_cycle", i), last_cyc, 2 + STABLE);
            end
            $display("vec %0d: an=%b seg=%h -> digits=%h valid=%b err=%b upd=%0d", i, vecs[i].an, vecs[i].seg, digits, valid, err, upd_n);
        end

        // Reset in the middle of a stable run, then recapture after release
        an  = 4'b0001;
        seg = 7'h6D;
        run(5);
        check("midrst_pre_upd_count", upd_n, 0);
        rst = 1'b1;
        #1;
        check("midrst_digits", {16'd0, digits}, 32'd0);
        check("midrst_valid", {28'd0, valid}, 32'd0);
        check("midrst_err", {28'd0, err}, 32'd0);
        check("midrst_upd", {31'd0, upd}, 32'd0);
        check("midrst_upd_idx", {29'd0, upd_idx}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midrst_hold_digits", {16'd0, digits}, 32'd0);
        rst = 1'b0;
        run(10);
        check("postrst_upd_count", upd_n, 1);
        check("postrst_upd_cycle", last_cyc, 2 + STABLE);
        check("postrst_upd_idx", last_idx, 0);
        check("postrst_digits", {16'd0, digits}, 32'h0005);
        check("postrst_valid", {28'd0, valid}, 32'h1);
        check("postrst_err", {28'd0, err}, 32'h0);
        $display("midrst: digits=%h valid=%b err=%b upd=%0d at cycle %0d", digits, valid, err, upd_n, last_cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
